// File: rtl/grid_scan.sv
`default_nettype none
// ============================================================================
//  Module      : grid_scan
//  Description : Pipelined grid locator. Maps a stream of screen pixels to
//                grid cells (2-cycle latency), flags separator lines, and
//                returns the stored cell type. Owns the cell array with a
//                single-cell write port and a sequenced full-grid clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module grid_scan #(
    parameter int SIZE_X         = 10,
    parameter int SIZE_Y         = 10,
    parameter int CELL_W         = 10,
    parameter int CELL_H         = 10,
    parameter int LINE_THICKNESS = 1,
    parameter int CELL_BITS      = 1,
    parameter int XBITS          = $clog2(SIZE_X + 1),
    parameter int YBITS          = $clog2(SIZE_Y + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic                 pix_valid,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    input  logic                 wr_en,
    input  logic [XBITS-1:0]     wr_x,
    input  logic [YBITS-1:0]     wr_y,
    input  logic [CELL_BITS-1:0] wr_data,
    input  logic                 clr_start,
    output logic                 busy,
    output logic                 out_valid,
    output logic                 out_inside,
    output logic                 out_line,
    output logic [XBITS-1:0]     out_cell_x,
    output logic [YBITS-1:0]     out_cell_y,
    output logic [CELL_BITS-1:0] out_cell_type
);

    localparam int               NCELLS   = SIZE_X * SIZE_Y;
    localparam int               IDXW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    // Extents are 11 bits wide so pos + extent never wraps.
    localparam logic [10:0]      EXT_X    = 11'(SIZE_X * CELL_W - LINE_THICKNESS);
    localparam logic [10:0]      EXT_Y    = 11'(SIZE_Y * CELL_H - LINE_THICKNESS);
    localparam logic [9:0]       LINE_X   = 10'(CELL_W - LINE_THICKNESS);
    localparam logic [9:0]       LINE_Y   = 10'(CELL_H - LINE_THICKNESS);
    localparam logic [XBITS-1:0] SENT_X   = XBITS'(SIZE_X);
    localparam logic [YBITS-1:0] SENT_Y   = YBITS'(SIZE_Y);
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCELLS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Stage-0 combinational geometry
    logic [9:0]       bx, by, rx, ry;
    logic             inside0, line0;
    logic [XBITS-1:0] cx_raw, cx0;
    logic [YBITS-1:0] cy_raw, cy0;

    // Pipeline registers
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_inside_q, s1_inside_d;
    logic                 s1_line_q, s1_line_d;
    logic [XBITS-1:0]     s1_cx_q, s1_cx_d;
    logic [YBITS-1:0]     s1_cy_q, s1_cy_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_inside_q, out_inside_d;
    logic                 out_line_q, out_line_d;
    logic [XBITS-1:0]     out_cell_x_q, out_cell_x_d;
    logic [YBITS-1:0]     out_cell_y_q, out_cell_y_d;
    logic [CELL_BITS-1:0] out_type_q, out_type_d;

    // Cell store and clear sequencer
    logic [CELL_BITS-1:0] cells_q [NCELLS];
    logic [CELL_BITS-1:0] cells_d [NCELLS];
    state_t               state_q, state_d;
    logic [IDXW-1:0]      clr_cnt_q, clr_cnt_d;
    logic [IDXW-1:0]      wr_idx, rd_idx;
    logic                 rd_hit;

    // Bias, bounds test and cell/remainder via comparator chains (no divider)
    always_comb begin
        bx      = pix_x - pos_x;
        by      = pix_y - pos_y;
        inside0 = ({1'b0, pix_x} >= {1'b0, pos_x}) && ({1'b0, pix_x} < ({1'b0, pos_x} + EXT_X)) &&
                  ({1'b0, pix_y} >= {1'b0, pos_y}) && ({1'b0, pix_y} < ({1'b0, pos_y} + EXT_Y));
        cx_raw  = '0;
        rx      = bx;
        for (int i = 1; i < SIZE_X; i++) begin
            if (bx >= 10'(i * CELL_W)) begin
                cx_raw = XBITS'(i);
                rx     = bx - 10'(i * CELL_W);
            end
        end
        cy_raw  = '0;
        ry      = by;
        for (int j = 1; j < SIZE_Y; j++) begin
            if (by >= 10'(j * CELL_H)) begin
                cy_raw = YBITS'(j);
                ry     = by - 10'(j * CELL_H);
            end
        end
        line0 = inside0 && ((rx >= LINE_X) || (ry >= LINE_Y));
        cx0   = (inside0 && !line0) ? cx_raw : SENT_X;
        cy0   = (inside0 && !line0) ? cy_raw : SENT_Y;
    end

    // Next values for both pipeline stages; stage 2 holds fields when idle
    always_comb begin
        s1_valid_d   = pix_valid;
        s1_inside_d  = inside0;
        s1_line_d    = line0;
        s1_cx_d      = cx0;
        s1_cy_d      = cy0;
        rd_idx       = IDXW'(int'(s1_cy_q) * SIZE_X + int'(s1_cx_q));
        rd_hit       = (s1_cx_q < SENT_X) && (s1_cy_q < SENT_Y);
        out_valid_d  = s1_valid_q;
        out_inside_d = out_inside_q;
        out_line_d   = out_line_q;
        out_cell_x_d = out_cell_x_q;
        out_cell_y_d = out_cell_y_q;
        out_type_d   = out_type_q;
        if (s1_valid_q) begin
            out_inside_d = s1_inside_q;
            out_line_d   = s1_line_q;
            out_cell_x_d = s1_cx_q;
            out_cell_y_d = s1_cy_q;
            out_type_d   = rd_hit ? cells_q[rd_idx] : '0;
        end
    end

    // Clear sequencer and write port; writes accepted only while idle
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cells_d   = cells_q;
        wr_idx    = IDXW'(int'(wr_y) * SIZE_X + int'(wr_x));
        case (state_q)
            ST_IDLE: begin
                if (wr_en && (wr_x < SENT_X) && (wr_y < SENT_Y)) begin
                    cells_d[wr_idx] = wr_data;
                end
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                cells_d[clr_cnt_q] = '0;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, array and pipeline registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            for (int k = 0; k < NCELLS; k++) cells_q[k] <= '0;
            s1_valid_q   <= 1'b0;
            s1_inside_q  <= 1'b0;
            s1_line_q    <= 1'b0;
            s1_cx_q      <= '0;
            s1_cy_q      <= '0;
            out_valid_q  <= 1'b0;
            out_inside_q <= 1'b0;
            out_line_q   <= 1'b0;
            out_cell_x_q <= '0;
            out_cell_y_q <= '0;
            out_type_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            cells_q      <= cells_d;
            s1_valid_q   <= s1_valid_d;
            s1_inside_q  <= s1_inside_d;
            s1_line_q    <= s1_line_d;
            s1_cx_q      <= s1_cx_d;
            s1_cy_q      <= s1_cy_d;
            out_valid_q  <= out_valid_d;
            out_inside_q <= out_inside_d;
            out_line_q   <= out_line_d;
            out_cell_x_q <= out_cell_x_d;
            out_cell_y_q <= out_cell_y_d;
            out_type_q   <= out_type_d;
        end
    end

    assign busy          = (state_q == ST_CLEAR);
    assign out_valid     = out_valid_q;
    assign out_inside    = out_inside_q;
    assign out_line      = out_line_q;
    assign out_cell_x    = out_cell_x_q;
    assign out_cell_y    = out_cell_y_q;
    assign out_cell_type = out_type_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grid_scan
//  Description : Self-checking bench for grid_scan against a behavioural
//                model (division/modulo geometry, 2-D cell array, clear
//                countdown).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_scan;

    localparam int SX = 10, SY = 10, CW = 10, CH = 10, LT = 1;

    logic       clk, rst_n;
    logic [9:0] pos_x, pos_y, pix_x, pix_y;
    logic       pix_valid, wr_en, clr_start, wr_data;
    logic [3:0] wr_x, wr_y;
    logic       busy, out_valid, out_inside, out_line, out_cell_type;
    logic [3:0] out_cell_x, out_cell_y;

    grid_scan dut (
        .clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .clr_start(clr_start), .busy(busy), .out_valid(out_valid),
        .out_inside(out_inside), .out_line(out_line),
        .out_cell_x(out_cell_x), .out_cell_y(out_cell_y),
        .out_cell_type(out_cell_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       ins;
        logic       line;
        logic [3:0] cx;
        logic [3:0] cy;
    } pix_t;

    int   n_vec, n_err;
    int   mcell [SY][SX];
    int   left;
    pix_t s1m;
    int   e_valid, e_ins, e_line, e_cx, e_cy, e_type;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic pix_t geom(input int px, input int py, input int ox, input int oy, input logic v);
        pix_t g;
        int   bx, by;
        bx     = (px - ox) & 1023;
        by     = (py - oy) & 1023;
        g.v    = v;
        g.ins  = (px >= ox) && (px < ox + SX * CW - LT) && (py >= oy) && (py < oy + SY * CH - LT);
        g.line = g.ins && (((bx % CW) >= CW - LT) || ((by % CH) >= CH - LT));
        g.cx   = (g.ins && !g.line) ? 4'(bx / CW) : 4'(SX);
        g.cy   = (g.ins && !g.line) ? 4'(by / CH) : 4'(SY);
        return g;
    endfunction

    task automatic model_reset();
        for (int y = 0; y < SY; y++) for (int x = 0; x < SX; x++) mcell[y][x] = 0;
        left = 0; s1m = '0;
        e_valid = 0; e_ins = 0; e_line = 0; e_cx = 0; e_cy = 0; e_type = 0;
    endtask

    // One clock: predict what the edge does, advance, then compare.
    task automatic tick();
        pix_t nxt;
        if (s1m.v) begin
            e_ins  = int'(s1m.ins);
            e_line = int'(s1m.line);
            e_cx   = int'(s1m.cx);
            e_cy   = int'(s1m.cy);
            e_type = (s1m.cx < SX && s1m.cy < SY) ? mcell[int'(s1m.cy)][int'(s1m.cx)] : 0;
        end
        e_valid = int'(s1m.v);
        nxt = geom(int'(pix_x), int'(pix_y), int'(pos_x), int'(pos_y), pix_valid);
        if (left > 0) begin
            mcell[(SX * SY - left) / SX][(SX * SY - left) % SX] = 0;
            left--;
        end else begin
            if (wr_en && wr_x < SX && wr_y < SY) mcell[int'(wr_y)][int'(wr_x)] = int'(wr_data);
            if (clr_start) left = SX * SY;
        end
        s1m = nxt;
        @(posedge clk); #1;
        chk("busy", busy, (left > 0) ? 1 : 0);
        chk("out_valid", out_valid, e_valid);
        chk("out_inside", out_inside, e_ins);
        chk("out_line", out_line, e_line);
        chk("out_cell_x", out_cell_x, e_cx);
        chk("out_cell_y", out_cell_y, e_cy);
        chk("out_cell_type", out_cell_type, e_type);
    endtask

    task automatic pix(input int x, input int y);
        pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic wr(input int x, input int y, input int d);
        wr_en = 1'b1; wr_x = 4'(x); wr_y = 4'(y); wr_data = d[0];
        tick();
        wr_en = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_inside"}, out_inside, 0);
        chk({tag, "_line"}, out_line, 0);
        chk({tag, "_cx"}, out_cell_x, 0);
        chk({tag, "_cy"}, out_cell_y, 0);
        chk({tag, "_type"}, out_cell_type, 0);
    endtask

    int bc;

    initial begin
        n_vec = 0; n_err = 0;
        pos_x = '0; pos_y = '0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = 1'b0; clr_start = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic geometry
        pix(25, 37); tick();
        chk("d_25_37_cx", out_cell_x, 2); chk("d_25_37_cy", out_cell_y, 3);
        chk("d_25_37_in", out_inside, 1); chk("d_25_37_valid", out_valid, 1);
        pix(29, 5); tick();
        chk("d_29_5_line", out_line, 1); chk("d_29_5_cx", out_cell_x, 10);
        pix(99, 0); pix(0, 99); tick();
        chk("d_0_99_in", out_inside, 0); chk("d_0_99_cy", out_cell_y, 10);
        pix(98, 98); tick();
        chk("d_98_98_cx", out_cell_x, 9); chk("d_98_98_line", out_line, 0);

        // Write vs. lookup ordering
        pix(25, 37);
        pix_valid = 1'b1; pix_x = 10'd25; pix_y = 10'd37;
        wr_en = 1'b1; wr_x = 4'd2; wr_y = 4'd3; wr_data = 1'b1;
        tick();
        wr_en = 1'b0; pix_valid = 1'b0;
        chk("d_wr_old", out_cell_type, 0);
        tick();
        chk("d_wr_new", out_cell_type, 1);
        wr(10, 0, 1);
        pix(5, 15); tick();
        chk("d_wr_oob", out_cell_type, 0);

        // Origin offsets
        pos_x = 10'd1000; pix(5, 5); tick();
        chk("d_nowrap", out_inside, 0);
        pos_x = 10'd50; pos_y = 10'd50; pix(50, 50); tick();
        chk("d_org_cx", out_cell_x, 0); chk("d_org_cy", out_cell_y, 0);
        pos_x = '0; pos_y = '0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                pos_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 40));
                pos_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 40));
            end
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_x     = 10'(int'(pos_x) + $urandom_range(0, 120));
            pix_y     = 10'(int'(pos_y) + $urandom_range(0, 120));
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_x      = 4'($urandom_range(0, 11));
            wr_y      = 4'($urandom_range(0, 11));
            wr_data   = 1'($urandom_range(0, 1));
            clr_start = ($urandom_range(0, 150) == 0);
            tick();
        end
        pix_valid = 1'b0; wr_en = 1'b0; clr_start = 1'b0; pos_x = '0; pos_y = '0;
        for (int n = 0; n < 120 && left > 0; n++) tick();

        // Fill, clear, busy length, write during busy
        for (int y = 0; y < SY; y++) for (int x = 0; x < SX; x++) wr(x, y, 1);
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        bc = (busy === 1'b1) ? 1 : 0;
        wr(0, 0, 1);
        if (busy === 1'b1) bc++;
        for (int n = 0; n < 150; n++) begin
            pix_valid = 1'b1;
            pix_x = 10'($urandom_range(0, 99)); pix_y = 10'($urandom_range(0, 99));
            tick();
            if (busy === 1'b1) bc++;
        end
        pix_valid = 1'b0;
        chk("busy_len", bc, 100);
        for (int y = 0; y < SY; y++) for (int x = 0; x < SX; x++) begin
            pix(x * CW + 4, y * CH + 4);
            if (out_valid === 1'b1) chk("cleared_type", out_cell_type, 0);
        end
        tick(); tick();

        // Reset in the middle of a clear
        for (int n = 0; n < 6; n++) wr($urandom_range(0, 9), $urandom_range(0, 9), 1);
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            pix_valid = 1'b1; pix_x = 10'($urandom_range(0, 99)); pix_y = 10'($urandom_range(0, 99));
            tick();
        end
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk_zero("midclr_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        chk("reclear_busy", busy, 1);
        for (int n = 0; n < 120 && left > 0; n++) tick();
        chk("reclear_done", busy, 0);
        pix(45, 45); tick();
        chk("final_type", out_cell_type, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grid_scan.md
Name: grid_scan

Overview:
- Pipelined, clocked successor to the combinational grid locator.
- Accepts a stream of screen pixel coordinates, one per clock, with a valid flag.
- Per pixel, returns the grid cell hit, whether the pixel lies on a cell separator line, and the stored cell type. Fixed latency is 2 cycles.
- Owns the grid contents as an internal register array with a single-cell write port and a sequenced full-grid clear. Sits between the VGA pixel counter and the colour mux.

Parameters:
- SIZE_X, 10, number of cells horizontally
- SIZE_Y, 10, number of cells vertically
- CELL_W, 10, cell pitch in pixels along x, separator included
- CELL_H, 10, cell pitch in pixels along y, separator included
- LINE_THICKNESS, 1, separator width in pixels at the right/bottom of each cell (must be < CELL_W and < CELL_H)
- CELL_BITS, 1, bits stored per cell
- XBITS, $clog2(SIZE_X+1), width of x cell index; holds the SIZE_X sentinel
- YBITS, $clog2(SIZE_Y+1), width of y cell index; holds the SIZE_Y sentinel

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pos_x  in  10  grid origin x on screen; quasi-static
- pos_y  in  10  grid origin y on screen; quasi-static
- pix_valid  in  1  pix_x/pix_y valid this cycle
- pix_x  in  10  pixel x coordinate
- pix_y  in  10  pixel y coordinate
- wr_en  in  1  write one cell this cycle
- wr_x  in  XBITS  write cell column
- wr_y  in  YBITS  write cell row
- wr_data  in  CELL_BITS  write value
- clr_start  in  1  pulse: start clearing the whole grid
- busy  out  1  clear in progress
- out_valid  out  1  pix_valid delayed 2 cycles
- out_inside  out  1  pixel inside grid rectangle
- out_line  out  1  pixel inside rectangle and on a separator
- out_cell_x  out  XBITS  cell column, or SIZE_X if not in a cell
- out_cell_y  out  YBITS  cell row, or SIZE_Y if not in a cell
- out_cell_type  out  CELL_BITS  stored cell value, or 0 if not in a cell

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0;
  - pipeline valid bits 0;
  - cell array all 0;
  - FSM to IDLE;
  - clear counter 0.
- Bias arithmetic:
  - bx = pix_x - pos_x, by = pix_y - pos_y, 10-bit unsigned, wrapping.
  - inside = (pix_x >= pos_x) & (pix_x < pos_x + SIZE_X*CELL_W - LINE_THICKNESS) & the same test for y. Compare on 11 bits so pos_x + extent cannot overflow.
- Stage 1 (registered at the first edge):
  - cx = bx / CELL_W when inside, built from a comparator chain, not a divider.
  - line = inside & ((bx mod CELL_W) >= CELL_W - LINE_THICKNESS, or the y equivalent).
  - If !inside or line: cx = SIZE_X and cy = SIZE_Y.
  - Register cx, cy, inside, line and valid.
- Stage 2 (registered at the second edge):
  - cell_type = array[cy][cx], or 0 if sentinel.
  - cx, cy, inside, line and valid are forwarded unchanged.
  - Outputs hold their last values when valid is 0; only out_valid drops.
- Throughput: one pixel per cycle, no stalls, no backpressure.
- Array read/write ordering: a write commits at the clock edge. A stage-2 capture at that same edge sees the old value. Captures on later edges see the new value.
- Write port:
  - In IDLE with wr_en = 1, array[wr_y][wr_x] <= wr_data.
  - wr_x >= SIZE_X or wr_y >= SIZE_Y: write ignored.
- FSM states: IDLE, CLEAR.
  - IDLE, clr_start = 1: go to CLEAR, counter = 0, busy = 1 from the next cycle.
  - CLEAR: each cycle, cell at linear index counter (row-major, idx = y*SIZE_X + x) <= 0, then counter += 1.
  - Leaving CLEAR: after writing index SIZE_X*SIZE_Y-1, go to IDLE and busy = 0 on the following cycle. busy is high for exactly SIZE_X*SIZE_Y cycles.
  - In CLEAR, wr_en and clr_start are ignored. Pixel lookups continue and return the current, partially cleared contents.
  - clr_start and wr_en in the same IDLE cycle: the write is performed and the clear starts next cycle, so the written cell is cleared.
- Reset mid-clear: immediate return to IDLE, busy = 0, array = 0.

Test Plan (defaults, pos_x = pos_y = 0 unless stated):
- Reset, then pix (25,37) valid → 2 cycles later: out_valid=1, inside=1, line=0, cell (2,3), type 0.
- pix (29,5) → inside=1, line=1, cell (10,10), type 0. pix (99,0) and pix (0,99) → inside=0, cell (10,10). pix (98,98) → inside=1, line=0, cell (9,9).
- Write (2,3)=1 at cycle t, pix (25,37) presented at t-1 → type 0. Presented at t → type 1. Write (10,0)=1 → no array change.
- pos_x=1000, pix_x=5 → inside=0, no wrap false-hit. pos_x=pos_y=50, pix (50,50) → cell (0,0).
- Fill all cells with 1, pulse clr_start → busy high exactly 100 cycles. A write during busy is ignored. Afterwards every pixel reads type 0.
- rst_n low at clear cycle 40 → busy=0 and outputs 0 asynchronously. After release, a new clr_start is accepted.
